mp_add_sequencer: RTL and testbench

Multi-precision add/subtract sequencer that drives a single WIDTH-bit `carry_lookahead_adder` over WORDS cycles. Operand words go through the adder LSW first, with the carry held in a register between words. It sits between a host that supplies wide operands with a start pulse and the narrow adder datapath, trading latency for area on the iCE40.

---
 rtl/mp_add_pkg.sv | 15 +
 rtl/carry_lookahead_adder.sv | 42 ++++
 rtl/mp_add_sequencer.sv | 121 ++++++++++++
 tb/tb_mp_add_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  // Sequencer FSM encoding: waiting for a start, or stepping through words.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Width of the word index; a single-word build still needs one bit.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit carry-lookahead adder with carry in and carry out.
module carry_lookahead_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             term;
  logic             chain;

  assign gen  = i_a & i_b;
  assign prop = i_a ^ i_b;

  // Each carry is the flat OR of every generate term propagated up to it,
  // plus the carry in propagated through all lower bits.
  always_comb begin
    carry    = '0;
    term     = 1'b0;
    chain    = 1'b1;
    carry[0] = i_cin;
    for (int i = 0; i < WIDTH; i++) begin
      term  = 1'b0;
      chain = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term  = term | (chain & gen[j]);
        chain = chain & prop[j];
      end
      carry[i+1] = term | (chain & i_cin);
    end
  end

  assign o_sum  = prop ^ carry[WIDTH-1:0];
  assign o_cout = carry[WIDTH];

endmodule

// File: rtl/mp_add_sequencer.sv
// Wide add/subtract performed one WIDTH-bit word per cycle, LSW first,
// through a single shared carry-lookahead adder.
import mp_add_pkg::*;

module mp_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_sub,
  input  logic [WORDS*WIDTH-1:0] i_a,
  input  logic [WORDS*WIDTH-1:0] i_b,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [WORDS*WIDTH-1:0] o_result,
  output logic                   o_cout,
  output logic                   o_overflow
);

  localparam int N     = WORDS * WIDTH;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             c_q, c_d;
  logic [N-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign add_a = a_q[idx_q*WIDTH +: WIDTH];
  assign add_b = b_q[idx_q*WIDTH +: WIDTH];

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a    (add_a),
    .i_b    (add_b),
    .i_cin  (c_q),
    .o_sum  (add_sum),
    .o_cout (add_cout)
  );

  // Next-state logic: capture operands on start (B inverted and carry-in
  // set for subtract), then fold one word per cycle until the top word.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_sub ? ~i_b : i_b;
          c_d     = i_sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[idx_q*WIDTH +: WIDTH] = add_sum;
        c_d   = add_cout;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_sum[WIDTH-1] != a_q[N-1]);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign o_busy     = (state_q == ST_RUN);
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_cout     = cout_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed self-checking bench for mp_add_sequencer (WIDTH=8, WORDS=4).
module tb_mp_add_sequencer;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  typedef struct packed {
    logic [N-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic         i_sub;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         o_busy;
  logic         o_done;
  logic [N-1:0] o_result;
  logic         o_cout;
  logic         o_overflow;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];

  mp_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_sub      (i_sub),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_cout     (o_cout),
    .o_overflow (o_overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-width reference: unsigned carry/borrow and signed range overflow.
  function automatic exp_t modelOp(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    exp_t             e;
    logic [N:0]       u;
    logic signed [N:0] s;
    if (sub) begin
      u      = {1'b0, a} - {1'b0, b};
      e.cout = (a >= b);
      s      = $signed({a[N-1], a}) - $signed({b[N-1], b});
    end else begin
      u      = {1'b0, a} + {1'b0, b};
      e.cout = u[N];
      s      = $signed({a[N-1], a}) + $signed({b[N-1], b});
    end
    e.res = u[N-1:0];
    e.ovf = (s[N] != s[N-1]);
    return e;
  endfunction

  function automatic exp_t mkExp(input logic [N-1:0] res, input logic cout, input logic ovf);
    exp_t e;
    e.res  = res;
    e.cout = cout;
    e.ovf  = ovf;
    return e;
  endfunction

  // Present operands with a start pulse across one rising edge; returns at
  // the falling edge after the accepting edge, with operands scrambled.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
    i_sub   = 1'($urandom_range(0, 1));
    checkOutput("busy_after_start", o_busy, 1);
    checkOutput("done_after_start", o_done, 0);
  endtask

  // Wait (bounded) for o_done, check latency and pop the scoreboard.
  task automatic waitDone(input string tag, input int exp_lat);
    int   lat;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
      checkOutput({tag, "_busy_run"}, o_busy, 1);
    end
    if (!seen) begin
      checkOutput({tag, "_done_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_busy_done"}, o_busy, 0);
      if (sb.size() == 0) begin
        checkOutput({tag, "_sb_underflow"}, 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput({tag, "_result"}, o_result, e.res);
        checkOutput({tag, "_cout"}, o_cout, e.cout);
        checkOutput({tag, "_ovf"}, o_overflow, e.ovf);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    i_sub   = 1'b0;
    i_a     = '0;
    i_b     = '0;

    #1;
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_result", o_result, 0);
    checkOutput("rst_cout", o_cout, 0);
    checkOutput("rst_ovf", o_overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Carry across a word, with done pulse width and hold behaviour.
    sb.push_back(mkExp(32'h0000_0100, 1'b0, 1'b0));
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0);
    waitDone("carry_word", 4);
    @(negedge clk);
    checkOutput("carry_word_done_clear", o_done, 0);
    checkOutput("carry_word_hold", o_result, 32'h0000_0100);
    checkOutput("carry_word_idle", o_busy, 0);

    sb.push_back(mkExp(32'h0000_0000, 1'b1, 1'b0));
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    waitDone("full_wrap", 4);

    sb.push_back(mkExp(32'h8000_0000, 1'b0, 1'b1));
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    waitDone("ovf_add", 4);

    sb.push_back(mkExp(32'h7FFF_FFFF, 1'b1, 1'b1));
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
    waitDone("ovf_sub", 4);

    // Reset between edges two cycles into RUN; outputs must clear at once.
    sb.push_back(mkExp(32'h1010_1010, 1'b0, 1'b0));
    applyStimulus(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_done", o_done, 0);
    checkOutput("midrst_result", o_result, 0);
    checkOutput("midrst_cout", o_cout, 0);
    checkOutput("midrst_ovf", o_overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_done", o_done, 0);
    end
    sb.push_back(mkExp(32'h0000_0002, 1'b0, 1'b0));
    applyStimulus(32'h0000_0001, 32'h0000_0001, 1'b0);
    waitDone("after_rst", 4);

    sb.push_back(mkExp(32'hFFFF_FFFF, 1'b0, 1'b0));
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b1);
    waitDone("borrow", 4);

    sb.push_back(mkExp(32'h0000_0000, 1'b1, 1'b0));
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1);
    waitDone("sub_equal", 4);

    // A start pulse in the middle of RUN must be ignored.
    sb.push_back(mkExp(32'h3333_3333, 1'b0, 1'b0));
    applyStimulus(32'h1111_1111, 32'h2222_2222, 1'b0);
    @(negedge clk);
    i_start = 1'b1;
    i_a     = 32'hDEAD_BEEF;
    i_b     = 32'h0BAD_F00D;
    @(negedge clk);
    i_start = 1'b0;
    waitDone("mid_run_start", 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("mid_run_no_extra_done", o_done, 0);
      checkOutput("mid_run_no_extra_busy", o_busy, 0);
    end

    // Start held high with changing operands: one acceptance every 5 edges.
    for (int k = 0; k < 15; k++) begin
      i_a     = $urandom;
      i_b     = $urandom;
      i_sub   = 1'($urandom_range(0, 1));
      i_start = 1'b1;
      if (k % 5 == 0) sb.push_back(modelOp(i_a, i_b, i_sub));
      @(negedge clk);
      if (k % 5 == 4) begin
        checkOutput("stream_done", o_done, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("stream_result", o_result, e.res);
          checkOutput("stream_cout", o_cout, e.cout);
          checkOutput("stream_ovf", o_overflow, e.ovf);
        end
      end else begin
        checkOutput("stream_no_done", o_done, 0);
      end
    end
    i_start = 1'b0;
    checkOutput("stream_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
